stream_packer: RTL

- Single-clock width upsizer on the read side of the async FIFO.
- Consumes the FIFO's DATA_WIDTH valid/ready stream in the rclk domain and packs RATIO consecutive beats into one wide word.
- Emits each word with per-lane keep bits and a last flag to the downstream consumer.
- Partial words are flushed on in_last, or on an optional idle timeout, so a trailing byte never stalls in the packer.

---
 rtl/stream_packer.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/stream_packer.sv
// Width upsizer: packs RATIO consecutive DATA_WIDTH beats into one wide word with
// per-lane keep and a last flag. Partial words flush on in_last or an idle timeout.
module stream_packer #(
    parameter int DATA_WIDTH = 8,
    parameter int RATIO      = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic [DATA_WIDTH-1:0]         in_data,
    input  logic                          in_last,
    output logic                          in_ready,
    output logic                          out_valid,
    output logic [DATA_WIDTH*RATIO-1:0]   out_data,
    output logic [RATIO-1:0]              out_keep,
    output logic                          out_last,
    input  logic                          out_ready
);

    localparam int LW = $clog2(RATIO + 1);

    logic [RATIO-1:0][DATA_WIDTH-1:0] acc_data_reg, acc_data_next;
    logic [RATIO-1:0]                 acc_keep_reg, acc_keep_next;
    logic [LW-1:0]                    lane_cnt_reg, lane_cnt_next;
    logic                             acc_last_reg, acc_last_next;
    logic                             acc_done_reg, acc_done_next;

    logic [DATA_WIDTH*RATIO-1:0]      out_data_reg, out_data_next;
    logic [RATIO-1:0]                 out_keep_reg, out_keep_next;
    logic                             out_last_reg, out_last_next;
    logic                             out_valid_reg, out_valid_next;

    logic                             accept;
    logic                             slot_free;
    logic                             beat_completes;
    logic                             timeout_fire;
    logic                             complete;
    logic                             load_out;
    logic [RATIO-1:0][DATA_WIDTH-1:0] merged_data;
    logic [RATIO-1:0]                 merged_keep;
    logic                             merged_last;

    assign in_ready  = !acc_done_reg;
    assign accept    = in_valid && in_ready;
    assign slot_free = !out_valid_reg || out_ready;

    // Accumulator contents as they would look with the current beat written in.
    generate
        for (genvar gi = 0; gi < RATIO; gi++) begin : g_lane
            logic lane_hit;
            assign lane_hit        = accept && (lane_cnt_reg == LW'(gi));
            assign merged_data[gi] = lane_hit ? in_data : acc_data_reg[gi];
            assign merged_keep[gi] = lane_hit | acc_keep_reg[gi];
        end
    endgenerate

    assign merged_last    = acc_last_reg | (accept & in_last);
    assign beat_completes = accept && ((lane_cnt_reg == LW'(RATIO - 1)) || in_last);
    assign complete       = beat_completes || timeout_fire;

    generate
        if (TIMEOUT > 0) begin : g_timeout
            localparam int IW = $clog2(TIMEOUT + 1);
            logic [IW-1:0] idle_cnt_reg;

            // An accepted beat in the expiry cycle wins; the timeout only fires on a true idle cycle.
            assign timeout_fire = !accept && !acc_done_reg && (lane_cnt_reg != '0)
                                  && (idle_cnt_reg == IW'(TIMEOUT));

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    idle_cnt_reg <= '0;
                end else if (timeout_fire || accept || acc_done_reg || (lane_cnt_reg == '0)) begin
                    idle_cnt_reg <= '0;
                end else if (idle_cnt_reg != IW'(TIMEOUT)) begin
                    idle_cnt_reg <= idle_cnt_reg + IW'(1);
                end
            end
        end else begin : g_no_timeout
            assign timeout_fire = 1'b0;
        end
    endgenerate

    always_comb begin
        acc_data_next  = acc_data_reg;
        acc_keep_next  = acc_keep_reg;
        lane_cnt_next  = lane_cnt_reg;
        acc_last_next  = acc_last_reg;
        acc_done_next  = acc_done_reg;
        out_data_next  = out_data_reg;
        out_keep_next  = out_keep_reg;
        out_last_next  = out_last_reg;
        out_valid_next = out_valid_reg;
        load_out       = 1'b0;

        if (acc_done_reg) begin
            // A finished word is parked in the accumulator waiting for the output slot.
            if (slot_free) begin
                load_out       = 1'b1;
                out_data_next  = acc_data_reg;
                out_keep_next  = acc_keep_reg;
                out_last_next  = acc_last_reg;
                acc_data_next  = '0;
                acc_keep_next  = '0;
                lane_cnt_next  = '0;
                acc_last_next  = 1'b0;
                acc_done_next  = 1'b0;
            end
        end else if (complete) begin
            if (slot_free) begin
                load_out       = 1'b1;
                out_data_next  = merged_data;
                out_keep_next  = merged_keep;
                out_last_next  = merged_last;
                acc_data_next  = '0;
                acc_keep_next  = '0;
                lane_cnt_next  = '0;
                acc_last_next  = 1'b0;
            end else begin
                acc_data_next  = merged_data;
                acc_keep_next  = merged_keep;
                acc_last_next  = merged_last;
                lane_cnt_next  = lane_cnt_reg + (accept ? LW'(1) : LW'(0));
                acc_done_next  = 1'b1;
            end
        end else if (accept) begin
            acc_data_next = merged_data;
            acc_keep_next = merged_keep;
            lane_cnt_next = lane_cnt_reg + LW'(1);
        end

        if (load_out) begin
            out_valid_next = 1'b1;
        end else if (out_ready) begin
            out_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_data_reg  <= '0;
            acc_keep_reg  <= '0;
            lane_cnt_reg  <= '0;
            acc_last_reg  <= 1'b0;
            acc_done_reg  <= 1'b0;
            out_data_reg  <= '0;
            out_keep_reg  <= '0;
            out_last_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            acc_data_reg  <= acc_data_next;
            acc_keep_reg  <= acc_keep_next;
            lane_cnt_reg  <= lane_cnt_next;
            acc_last_reg  <= acc_last_next;
            acc_done_reg  <= acc_done_next;
            out_data_reg  <= out_data_next;
            out_keep_reg  <= out_keep_next;
            out_last_reg  <= out_last_next;
            out_valid_reg <= out_valid_next;
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_keep  = out_keep_reg;
    assign out_last  = out_last_reg;

endmodule
